// File: rtl/wf_rr_arbiter_pkg.sv
// Shared definitions for the wavefront round-robin arbiter: sizing and the
// two-state grant FSM encoding.
package wf_rr_arbiter_pkg;

  localparam int unsigned GLB_NUM_WF  = 40;
  localparam int unsigned GLB_WFID_W  = 6;
  localparam int unsigned GLB_PTR_RST = GLB_NUM_WF - 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wf_rr_find_first.sv
// Stateless rotating priority encoder: first set bit of req at ptr+1, ptr+2, ...
// wrapping modulo NUM_WF and ending at ptr itself.
module wf_rr_find_first
  import wf_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_WF = GLB_NUM_WF,
  parameter int unsigned WFID_W = GLB_WFID_W
) (
  input  logic [NUM_WF-1:0] req,
  input  logic [WFID_W-1:0] ptr,
  output logic              found,
  output logic [WFID_W-1:0] id,
  output logic [NUM_WF-1:0] onehot
);

  int unsigned        cand;
  logic [WFID_W-1:0]  cand_id;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    found   = 1'b0;
    id      = '0;
    onehot  = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned k = NUM_WF; k >= 1; k--) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_WF) cand = cand - NUM_WF;
      cand_id = WFID_W'(cand);
      if (req[cand_id]) begin
        found           = 1'b1;
        id              = cand_id;
        onehot          = '0;
        onehot[cand_id] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wf_rr_arbiter.sv
// Round-robin wavefront issue arbiter with registered grant, valid/ready
// handshake, synchronous flush and a pointer tracking the last accepted id.
module wf_rr_arbiter
  import wf_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_WF  = GLB_NUM_WF,
  parameter int unsigned WFID_W  = GLB_WFID_W,
  parameter int unsigned PTR_RST = GLB_PTR_RST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] req,
  input  logic              clear,
  input  logic              grant_ready,
  output logic              grant_valid,
  output logic [WFID_W-1:0] grant_wfid,
  output logic [NUM_WF-1:0] grant_onehot,
  output logic [WFID_W-1:0] ptr
);

  arb_state_e        state;
  logic              accept;
  logic              load;
  logic [NUM_WF-1:0] req_masked;
  logic [WFID_W-1:0] search_ptr;
  logic              ff_found;
  logic [WFID_W-1:0] ff_id;
  logic [NUM_WF-1:0] ff_onehot;

  assign grant_valid = (state == ST_HOLD);
  assign accept      = grant_valid & grant_ready;
  assign load        = ~grant_valid | grant_ready;

  // On acceptance the reload search already starts after the accepted id
  // (the pointer value being written this edge) and excludes that id.
  always_comb begin
    req_masked = req;
    search_ptr = ptr;
    if (accept) begin
      req_masked = req & ~grant_onehot;
      search_ptr = grant_wfid;
    end
  end

  wf_rr_find_first #(
    .NUM_WF (NUM_WF),
    .WFID_W (WFID_W)
  ) u_find_first (
    .req    (req_masked),
    .ptr    (search_ptr),
    .found  (ff_found),
    .id     (ff_id),
    .onehot (ff_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant_wfid   <= '0;
      grant_onehot <= '0;
      ptr          <= WFID_W'(PTR_RST);
    end else if (clear) begin
      state        <= ST_IDLE;
      grant_wfid   <= '0;
      grant_onehot <= '0;
    end else begin
      if (accept) ptr <= grant_wfid;
      if (load) begin
        state        <= ff_found ? ST_HOLD : ST_IDLE;
        grant_wfid   <= ff_found ? ff_id : '0;
        grant_onehot <= ff_found ? ff_onehot : '0;
      end
    end
  end

endmodule

// File: doc/wf_rr_arbiter.md
WF_RR_ARBITER -- requirements
Module: wf_rr_arbiter

Interface
REQ-001 Parameter NUM_WF, default 40: number of wavefront request lines.
REQ-002 Parameter WFID_W, default 6: width of a wavefront id.
REQ-003 Parameter PTR_RST, default 39: reset value of the priority pointer, so the first search starts at id 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NUM_WF  per-wavefront request; bit i = wavefront i ready to issue.
REQ-007 clear  input  1  synchronous flush; drops any held grant.
REQ-008 grant_ready  input  1  downstream accepts the presented grant this cycle.
REQ-009 grant_valid  output  1  a registered grant is presented.
REQ-010 grant_wfid  output  WFID_W  id of the granted wavefront.
REQ-011 grant_onehot  output  NUM_WF  one-hot form of grant_wfid; all zero when grant_valid=0.
REQ-012 ptr  output  WFID_W  current priority pointer (last accepted id).

Function
REQ-013 Outputs SHALL be registered; a request on cycle N with no grant held SHALL produce grant_valid=1 on cycle N+1.
REQ-014 Search order SHALL be ptr+1, ptr+2, ... wrapping from NUM_WF-1 to 0, ending at ptr itself.
REQ-015 Wrap arithmetic SHALL be modulo NUM_WF, not modulo 2^WFID_W; ptr=39 SHALL yield first candidate 0.
REQ-016 A new grant SHALL load only when grant_valid=0, or when grant_valid=1 and grant_ready=1.
REQ-017 While grant_valid=1 and grant_ready=0, grant_wfid and grant_onehot SHALL hold stable, even if the granted req bit deasserts.
REQ-018 On acceptance (grant_valid & grant_ready), ptr SHALL load grant_wfid on the same edge.
REQ-019 On acceptance, the accepted id SHALL be masked out of req for the reload search on that edge, preventing back-to-back double grant.
REQ-020 If no eligible request exists at a load opportunity, grant_valid SHALL go to 0 and grant_onehot to zero.
REQ-021 clear=1 SHALL force grant_valid=0 next edge and SHALL NOT update ptr; clear has priority over acceptance and reload.
REQ-022 A single request SHALL be regranted every cycle it is accepted, except the cycle right after acceptance (masking per REQ-019).
REQ-023 With all requests asserted and grant_ready=1 continuously, grants SHALL cycle 0,2,4,... only if masking skips; masking SHALL skip solely the just-accepted id, giving strict sequence 0,1,2,...,39,0.
REQ-024 States: IDLE (grant_valid=0) and HOLD (grant_valid=1); IDLE->HOLD on any eligible req; HOLD->HOLD on stall or accept-with-reload; HOLD->IDLE on accept-without-eligible or clear.

Reset
REQ-025 On rst, grant_valid=0, grant_wfid=0, grant_onehot=0, ptr=PTR_RST, immediately and independent of clk.
REQ-026 Reset asserted mid-grant SHALL discard the grant without pointer update; first post-reset search SHALL start at PTR_RST+1 mod NUM_WF.

Structure
REQ-027 NUM_WF and WFID_W SHALL come from the shared global definitions; no local redefinition.
REQ-028 One sub-module SHALL exist: wf_rr_find_first, combinational rotating priority encoder (inputs masked req, ptr; outputs found, id, onehot).
REQ-029 All flops SHALL reside in wf_rr_arbiter; wf_rr_find_first SHALL be stateless.

Verification
REQ-030 Reset, req=bit 5 only, grant_ready=1 -> grant_wfid=5 next cycle, ptr=5 after acceptance.
REQ-031 ptr=39, req bits 0 and 39 -> grant_wfid=0 (wrap check).
REQ-032 All 40 req set, grant_ready=1 for 45 cycles -> grants 0..39 then 0..4, no repeats or skips.
REQ-033 Grant 7 held, grant_ready=0 for 5 cycles, req bit 7 dropped -> grant_wfid stays 7, ptr unchanged.
REQ-034 grant_valid=1, clear=1 and grant_ready=1 same cycle -> grant_valid=0 next, ptr unchanged.
REQ-035 rst asserted between clock edges while grant_valid=1 -> outputs zero, ptr=39 before next edge.
